// File: rtl/mem_access_ctrl.sv
// Memory-stage request controller: takes one load/store at a time from execute,
// drives the LSU's AR/R/AW/W/B channels and hands the result to write-back.
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_mtype,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err,

    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        mrtypeM,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rresp,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t            state_q;
    logic              inReady_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        mtype_q;
    logic [DATA_W-1:0] laneData_q;
    logic [3:0]        strb_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic              awDone_q;
    logic              wDone_q;
    logic              outValid_q;
    logic              outErr_q;
    logic [DATA_W-1:0] outRdata_q;

    logic              misaligned_d;
    logic [3:0]        strb_d;
    logic [DATA_W-1:0] laneData_d;
    logic              accept;
    logic              awFire;
    logic              wFire;
    logic              awDone_d;
    logic              wDone_d;

    assign accept   = in_valid & inReady_q;
    assign awFire   = awvalid_q & awready;
    assign wFire    = wvalid_q & wready;
    assign awDone_d = awDone_q | awFire;
    assign wDone_d  = wDone_q | wFire;

    // Alignment and store lane formatting are decided from the raw request so
    // the bus-facing registers are ready the cycle after acceptance.
    always_comb begin
        misaligned_d = 1'b0;
        strb_d       = 4'b1111;
        laneData_d   = in_wdata;
        if (in_is_load) begin
            case (in_mtype)
                3'd1, 3'd4: misaligned_d = in_addr[0];
                3'd2:       misaligned_d = (in_addr[1:0] != 2'b00);
                default:    misaligned_d = 1'b0;
            endcase
        end else if (in_is_store) begin
            case (in_mtype)
                3'd0: begin
                    strb_d     = 4'b0001 << in_addr[1:0];
                    laneData_d = {4{in_wdata[7:0]}};
                end
                3'd1: begin
                    misaligned_d = in_addr[0];
                    strb_d       = 4'b0011 << in_addr[1:0];
                    laneData_d   = {2{in_wdata[15:0]}};
                end
                default: misaligned_d = (in_addr[1:0] != 2'b00);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            addr_q     <= '0;
            mtype_q    <= '0;
            laneData_q <= '0;
            strb_q     <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            awDone_q   <= 1'b0;
            wDone_q    <= 1'b0;
            outValid_q <= 1'b0;
            outErr_q   <= 1'b0;
            outRdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= in_addr;
                        mtype_q    <= in_mtype;
                        laneData_q <= laneData_d;
                        strb_q     <= strb_d;
                        inReady_q  <= 1'b0;
                        if (misaligned_d || !(in_is_load || in_is_store)) begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                            outErr_q   <= misaligned_d;
                            outRdata_q <= '0;
                        end else if (in_is_load) begin
                            state_q   <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end else begin
                            state_q   <= WR_REQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awDone_q  <= 1'b0;
                            wDone_q   <= 1'b0;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        state_q   <= RD_DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        state_q    <= DONE;
                        rready_q   <= 1'b0;
                        outValid_q <= 1'b1;
                        outRdata_q <= rdata;
                        outErr_q   <= rresp;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently; either may finish first.
                    if (awFire) awvalid_q <= 1'b0;
                    if (wFire)  wvalid_q  <= 1'b0;
                    awDone_q <= awDone_d;
                    wDone_q  <= wDone_d;
                    if (awDone_d && wDone_d) begin
                        state_q  <= WR_RESP;
                        bready_q <= 1'b1;
                        awDone_q <= 1'b0;
                        wDone_q  <= 1'b0;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        state_q    <= DONE;
                        bready_q   <= 1'b0;
                        outValid_q <= 1'b1;
                        outRdata_q <= '0;
                        outErr_q   <= bresp;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    inReady_q  <= 1'b1;
                    arvalid_q  <= 1'b0;
                    rready_q   <= 1'b0;
                    awvalid_q  <= 1'b0;
                    wvalid_q   <= 1'b0;
                    bready_q   <= 1'b0;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_rdata = outRdata_q;
    assign out_err   = outErr_q;
    assign araddr    = addr_q;
    assign mrtypeM   = mtype_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awaddr    = addr_q;
    assign awvalid   = awvalid_q;
    assign wdata     = laneData_q;
    assign wstrb     = strb_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the bench plays the LSU slave
// by hand, driving on and sampling at the falling clock edge.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_mtype;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;
    logic [31:0] araddr;
    logic [2:0]  mrtypeM;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bresp;
    logic        bvalid;
    logic        bready;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_mtype(in_mtype),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .araddr(araddr), .mrtypeM(mrtypeM), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one request at a falling edge; returns at the falling edge of cycle 1.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wd,
                                 input logic isLoad, input logic isStore, input logic [2:0] mtype);
        in_valid    = 1'b1;
        in_addr     = addr;
        in_wdata    = wd;
        in_is_load  = isLoad;
        in_is_store = isStore;
        in_mtype    = mtype;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
    endtask

    task automatic finishResult(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_is_load = 1'b0; in_is_store = 1'b0; in_mtype = '0;
        out_ready = 1'b0;
        arready = 1'b0; rdata = '0; rresp = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 1'b0; bvalid = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_rdata", out_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned lw, zero-wait slave
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 1'b0;
        applyStimulus(32'h8000_0004, 32'd0, 1'b1, 1'b0, 3'd2);
        checkOutput("lw_arvalid", 32'(arvalid), 32'd1);
        checkOutput("lw_araddr", araddr, 32'h8000_0004);
        checkOutput("lw_mrtype", 32'(mrtypeM), 32'd2);
        checkOutput("lw_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("lw_rready", 32'(rready), 32'd1);
        checkOutput("lw_arvalid_drop", 32'(arvalid), 32'd0);
        @(negedge clk);
        checkOutput("lw_out_valid_c3", 32'(out_valid), 32'd1);
        checkOutput("lw_rdata", out_rdata, 32'hDEAD_BEEF);
        checkOutput("lw_err", 32'(out_err), 32'd0);
        rvalid = 1'b0; arready = 1'b0;
        finishResult("lw");

        // Non-memory op completes immediately with zero result
        applyStimulus(32'h8000_0001, 32'd0, 1'b0, 1'b0, 3'd2);
        checkOutput("nop_out_valid", 32'(out_valid), 32'd1);
        checkOutput("nop_rdata", out_rdata, 32'd0);
        checkOutput("nop_err", 32'(out_err), 32'd0);
        checkOutput("nop_arvalid", 32'(arvalid), 32'd0);
        finishResult("nop");

        // sb at byte 3, AW delayed, W immediate
        awready = 1'b0; wready = 1'b1;
        applyStimulus(32'h8000_0003, 32'h0000_00A5, 1'b0, 1'b1, 3'd0);
        checkOutput("sb_wstrb", 32'(wstrb), 32'h8);
        checkOutput("sb_wdata", wdata, 32'hA5A5_A5A5);
        checkOutput("sb_awaddr", awaddr, 32'h8000_0003);
        checkOutput("sb_wvalid_c1", 32'(wvalid), 32'd1);
        checkOutput("sb_awvalid_c1", 32'(awvalid), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("sb_awvalid_c%0d", k), 32'(awvalid), 32'd1);
            checkOutput($sformatf("sb_wvalid_c%0d", k), 32'(wvalid), 32'd0);
            checkOutput($sformatf("sb_bready_c%0d", k), 32'(bready), 32'd0);
        end
        awready = 1'b1;
        @(negedge clk);
        checkOutput("sb_awvalid_drop", 32'(awvalid), 32'd0);
        checkOutput("sb_bready", 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = 1'b0;
        @(negedge clk);
        bvalid = 1'b0;
        checkOutput("sb_out_valid", 32'(out_valid), 32'd1);
        checkOutput("sb_err", 32'(out_err), 32'd0);
        checkOutput("sb_bready_drop", 32'(bready), 32'd0);
        finishResult("sb");

        // sh at halfword 1, AW and W in the same cycle, error response
        awready = 1'b1; wready = 1'b1;
        applyStimulus(32'h8000_0002, 32'h1234_BEEF, 1'b0, 1'b1, 3'd1);
        checkOutput("sh_wstrb", 32'(wstrb), 32'hC);
        checkOutput("sh_wdata", wdata, 32'hBEEF_BEEF);
        @(negedge clk);
        checkOutput("sh_awvalid_drop", 32'(awvalid), 32'd0);
        checkOutput("sh_wvalid_drop", 32'(wvalid), 32'd0);
        checkOutput("sh_bready", 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = 1'b1;
        @(negedge clk);
        bvalid = 1'b0; bresp = 1'b0;
        checkOutput("sh_out_valid", 32'(out_valid), 32'd1);
        checkOutput("sh_err", 32'(out_err), 32'd1);
        checkOutput("sh_rdata", out_rdata, 32'd0);
        finishResult("sh");

        // Store with mtype 7 behaves as sw, so a half-aligned address is rejected
        applyStimulus(32'h8000_0006, 32'h1111_2222, 1'b0, 1'b1, 3'd7);
        checkOutput("sw7_out_valid", 32'(out_valid), 32'd1);
        checkOutput("sw7_err", 32'(out_err), 32'd1);
        checkOutput("sw7_awvalid", 32'(awvalid), 32'd0);
        finishResult("sw7");
        awready = 1'b0; wready = 1'b0;

        // Misaligned lh
        applyStimulus(32'h8000_0001, 32'd0, 1'b1, 1'b0, 3'd1);
        checkOutput("lh_mis_arvalid", 32'(arvalid), 32'd0);
        checkOutput("lh_mis_out_valid", 32'(out_valid), 32'd1);
        checkOutput("lh_mis_err", 32'(out_err), 32'd1);
        checkOutput("lh_mis_rdata", out_rdata, 32'd0);
        finishResult("lh_mis");

        // lbu with rvalid delayed 5 cycles and an error response
        arready = 1'b1; rvalid = 1'b0;
        applyStimulus(32'h8000_0011, 32'd0, 1'b1, 1'b0, 3'd3);
        checkOutput("lbu_arvalid", 32'(arvalid), 32'd1);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("lbu_rready_c%0d", k), 32'(rready), 32'd1);
            checkOutput($sformatf("lbu_mrtype_c%0d", k), 32'(mrtypeM), 32'd3);
            checkOutput($sformatf("lbu_ovalid_c%0d", k), 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        checkOutput("lbu_rready_c7", 32'(rready), 32'd1);
        rvalid = 1'b1; rresp = 1'b1; rdata = 32'h1234_5678;
        @(negedge clk);
        rvalid = 1'b0; rresp = 1'b0;
        checkOutput("lbu_out_valid", 32'(out_valid), 32'd1);
        checkOutput("lbu_err", 32'(out_err), 32'd1);
        checkOutput("lbu_rdata", out_rdata, 32'h1234_5678);
        checkOutput("lbu_rready_drop", 32'(rready), 32'd0);

        // Backpressure in DONE with the next request already waiting
        arready = 1'b0;
        in_valid = 1'b1; in_addr = 32'h8000_0020; in_is_load = 1'b1; in_mtype = 3'd2;
        for (int k = 9; k <= 11; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_out_valid_c%0d", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_rdata_c%0d", k), out_rdata, 32'h1234_5678);
            checkOutput($sformatf("bp_err_c%0d", k), 32'(out_err), 32'd1);
            checkOutput($sformatf("bp_in_ready_c%0d", k), 32'(in_ready), 32'd0);
            checkOutput($sformatf("bp_arvalid_c%0d", k), 32'(arvalid), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_out_valid_clr", 32'(out_valid), 32'd0);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_not_early", 32'(arvalid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; in_is_load = 1'b0;
        checkOutput("bp_next_arvalid", 32'(arvalid), 32'd1);
        checkOutput("bp_next_araddr", araddr, 32'h8000_0020);
        checkOutput("bp_next_in_ready", 32'(in_ready), 32'd0);

        // Asynchronous reset in the middle of RD_ADDR
        @(negedge clk);
        checkOutput("ar_hold_arvalid", 32'(arvalid), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_arvalid", 32'(arvalid), 32'd0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_out_rdata", out_rdata, 32'd0);
        checkOutput("arst_araddr", araddr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Fresh lw after reset
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 1'b0;
        applyStimulus(32'h8000_0008, 32'd0, 1'b1, 1'b0, 3'd2);
        checkOutput("lw2_arvalid", 32'(arvalid), 32'd1);
        checkOutput("lw2_araddr", araddr, 32'h8000_0008);
        @(negedge clk);
        checkOutput("lw2_rready", 32'(rready), 32'd1);
        @(negedge clk);
        checkOutput("lw2_out_valid", 32'(out_valid), 32'd1);
        checkOutput("lw2_rdata", out_rdata, 32'hCAFE_F00D);
        checkOutput("lw2_err", 32'(out_err), 32'd0);
        rvalid = 1'b0; arready = 1'b0;
        finishResult("lw2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
